bus_arbiter_rr: RTL and testbench

//   Round-robin scheduler for the shared data bus.
//   - Each of `drivers` ports has an input FIFO (pndng/pop/D_pop) and an output FIFO (push/full).
//   - Grants one pending port, pops one packet and routes it by its ID field:

---
 rtl/bus_arbiter_rr_if.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 127 ++++++++++++
 tb/tb_bus_arbiter_rr.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_rr_if.sv
// rtl/bus_arbiter_rr_if.sv - FIFO-side handshake bundle for the round-robin bus arbiter
interface bus_arbiter_rr_if #(
  parameter int width   = 16,
  parameter int drivers = 4
);
  logic [drivers-1:0]       pndng;
  logic [drivers*width-1:0] D_pop;
  logic [drivers-1:0]       pop;
  logic [drivers-1:0]       full;
  logic [drivers-1:0]       push;
  logic [width-1:0]         D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    input  full,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    output full,
    input  push,
    input  D_push
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin packet scheduler for the shared data bus
// Optional drop counter output enabled by ARB_DROP_CNT_EN.
module bus_arbiter_rr #(
  parameter int              width   = 16,
  parameter int              drivers = 4,
  parameter int              id_w    = 8,
  parameter logic [id_w-1:0] bcast   = '1
) (
  input  logic                       clk,
  input  logic                       reset,
  bus_arbiter_rr_if.master           bus,
  output logic                       bus_busy,
  output logic [$clog2(drivers)-1:0] grant_id
`ifdef ARB_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int gw = $clog2(drivers);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    ROUTE,
    PUSH
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [gw-1:0]      grant;
  logic [width-1:0]   pkt_reg;
  logic [id_w-1:0]    dest;
  logic [drivers-1:0] mask;
  logic [drivers-1:0] pop_c;
  logic [drivers-1:0] push_c;
  logic [width-1:0]   dpush_c;
  logic               found;
  logic [gw-1:0]      sel;

  // The grant register doubles as the round-robin pointer: search starts one past it.
  always_comb begin
    found = 1'b0;
    sel   = grant;
    for (int k = 1; k <= drivers; k++) begin
      if (!found && bus.pndng[(int'(grant) + k) % drivers]) begin
        found = 1'b1;
        sel   = gw'((int'(grant) + k) % drivers);
      end
    end
  end

  assign dest = pkt_reg[width-1 -: id_w];

  // Broadcast skips the source; unicast to self or out-of-range yields an empty mask.
  always_comb begin
    mask = '0;
    for (int i = 0; i < drivers; i++) begin
      if (dest == bcast) begin
        mask[i] = (gw'(i) != grant);
      end else begin
        mask[i] = (dest == id_w'(i)) && (gw'(i) != grant);
      end
    end
  end

  always_comb begin
    next_state = state;
    pop_c      = '0;
    push_c     = '0;
    dpush_c    = '0;
    case (state)
      IDLE: begin
        if (found) next_state = POP;
      end
      POP: begin
        pop_c[grant] = 1'b1;
        next_state   = ROUTE;
      end
      ROUTE: begin
        dpush_c = pkt_reg;
        if (mask == '0) begin
          next_state = IDLE;
        end else if ((mask & bus.full) == '0) begin
          next_state = PUSH;
        end
      end
      PUSH: begin
        dpush_c    = pkt_reg;
        push_c     = mask;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      grant   <= gw'(drivers - 1);
      pkt_reg <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && found) grant <= sel;
      if (state == POP) pkt_reg <= bus.D_pop[int'(grant)*width +: width];
    end
  end

`ifdef ARB_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (state == ROUTE && mask == '0 && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  // Dropped packets leave no trace.
`endif

  assign bus.pop    = pop_c;
  assign bus.push   = push_c;
  assign bus.D_push = dpush_c;
  assign bus_busy   = (state != IDLE);
  assign grant_id   = grant;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed self-checking bench for bus_arbiter_rr
module tb_bus_arbiter_rr;

  logic       clk;
  logic       reset;
  logic       bus_busy;
  logic [1:0] grant_id;
`ifdef ARB_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_checks;
  int n_errors;

  bus_arbiter_rr_if #(.width(16), .drivers(4)) bus ();

  bus_arbiter_rr #(
    .width(16),
    .drivers(4),
    .id_w(8),
    .bcast(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .bus_busy(bus_busy),
    .grant_id(grant_id)
`ifdef ARB_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    bus.D_pop[i*16 +: 16] = w;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  // Invariants that must hold in every cycle.
  always @(negedge clk) begin
    if (reset) begin
      check("pop_push_excl", {31'd0, (|bus.pop) && (|bus.push)}, 32'd0);
      check("pop_onehot0", {31'd0, $countones(bus.pop) > 1}, 32'd0);
    end
  end

  // Port i addresses port (i+1)%4 with payload A0+i in the fairness run.
  logic [15:0] fair_word [4] = '{16'h01A0, 16'h02A1, 16'h03A2, 16'h00A3};
  int          fair_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    bus.pndng = '0;
    bus.full  = '0;
    bus.D_pop = '0;

    do_reset();
    check("rst_pop", bus.pop, 4'b0000);
    check("rst_push", bus.push, 4'b0000);
    check("rst_busy", bus_busy, 1'b0);
    check("rst_grant", grant_id, 2'd3);
    check("rst_dpush", bus.D_push, 16'h0000);

    // Single unicast 0 -> 2
    bus.pndng = 4'b0001;
    set_word(0, 16'h0255);
    step();
    check("uni_pop", bus.pop, 4'b0001);
    check("uni_grant", grant_id, 2'd0);
    check("uni_busy", bus_busy, 1'b1);
    bus.pndng = 4'b0000;
    step();
    check("uni_route_push", bus.push, 4'b0000);
    check("uni_route_dpush", bus.D_push, 16'h0255);
    step();
    check("uni_push", bus.push, 4'b0100);
    check("uni_dpush", bus.D_push, 16'h0255);
    step();
    check("uni_idle_busy", bus_busy, 1'b0);
    check("uni_idle_dpush", bus.D_push, 16'h0000);

    // Fairness with all ports pending
    do_reset();
    for (int i = 0; i < 4; i++) set_word(i, fair_word[i]);
    bus.pndng = 4'b1111;
    for (int p = 0; p < 8; p++) begin
      step();
      check("fair_pop", bus.pop, oh(fair_order[p]));
      check("fair_grant", grant_id, fair_order[p]);
      step();
      step();
      check("fair_push", bus.push, oh((fair_order[p] + 1) % 4));
      check("fair_dpush", bus.D_push, fair_word[fair_order[p]]);
      step();
    end
    bus.pndng = 4'b0100;
    step();
    check("alone_pop", bus.pop, 4'b0100);
    check("alone_grant", grant_id, 2'd2);
    bus.pndng = 4'b0000;
    step();
    step();
    step();

    // Broadcast from port 1
    do_reset();
    bus.pndng = 4'b0010;
    set_word(1, 16'hFF3C);
    step();
    check("bc_pop", bus.pop, 4'b0010);
    bus.pndng = 4'b0000;
    step();
    check("bc_route_push", bus.push, 4'b0000);
    step();
    check("bc_push", bus.push, 4'b1101);
    check("bc_dpush", bus.D_push, 16'hFF3C);
    step();
    check("bc_idle_push", bus.push, 4'b0000);

    // Backpressure on port 3 for five ROUTE cycles
    do_reset();
    bus.full  = 4'b1000;
    bus.pndng = 4'b0001;
    set_word(0, 16'h03AA);
    step();
    check("bp_pop", bus.pop, 4'b0001);
    bus.pndng = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_stall_push", bus.push, 4'b0000);
      check("bp_stall_dpush", bus.D_push, 16'h03AA);
      check("bp_stall_busy", bus_busy, 1'b1);
    end
    bus.full = 4'b0000;
    step();
    check("bp_push", bus.push, 4'b1000);
    check("bp_dpush", bus.D_push, 16'h03AA);
    step();

    // Drops: out-of-range destination, then self
    do_reset();
    bus.pndng = 4'b0100;
    set_word(2, 16'h0711);
    step();
    check("drop1_pop", bus.pop, 4'b0100);
    bus.pndng = 4'b0000;
    step();
    check("drop1_route_push", bus.push, 4'b0000);
    step();
    check("drop1_idle_push", bus.push, 4'b0000);
    check("drop1_idle_busy", bus_busy, 1'b0);
    bus.pndng = 4'b0100;
    set_word(2, 16'h0222);
    step();
    check("drop2_pop", bus.pop, 4'b0100);
    check("drop2_grant", grant_id, 2'd2);
    bus.pndng = 4'b0000;
    step();
    check("drop2_route_push", bus.push, 4'b0000);
    step();
    check("drop2_idle_push", bus.push, 4'b0000);
    check("drop2_idle_busy", bus_busy, 1'b0);
`ifdef ARB_DROP_CNT_EN
    check("drop_cnt", drop_cnt, 8'd2);
`endif

    // Reset while in ROUTE
    do_reset();
    bus.pndng = 4'b0010;
    set_word(1, 16'h0011);
    step();
    check("mid_pop", bus.pop, 4'b0010);
    bus.pndng = 4'b0000;
    step();
    check("mid_in_route", bus.D_push, 16'h0011);
    reset = 1'b0;
    step();
    check("mid_push", bus.push, 4'b0000);
    check("mid_busy", bus_busy, 1'b0);
    check("mid_grant", grant_id, 2'd3);
    reset = 1'b1;
    step();
    check("mid_no_late_push", bus.push, 4'b0000);
    for (int i = 0; i < 4; i++) set_word(i, fair_word[i]);
    bus.pndng = 4'b1111;
    step();
    check("mid_next_pop", bus.pop, 4'b0001);
    check("mid_next_grant", grant_id, 2'd0);
    bus.pndng = 4'b0000;
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
